// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, types and helpers for the SHA-256 block loader
//
// Purpose:
//   Common definitions for sha256_block_loader and its block buffer sub-module.
//   BLOCK_BITS  : width of one SHA-256 message block.
//   MAX_BUF     : largest supported number of block buffers.
//   wpb()       : host words per block for a given host word width.
//   blk_flags_t : first/last-of-message flags captured with each block.
//   ld_state_e  : loader fill state (IDLE = no partial block, FILL = partial block).
// Ports: none (package).

package sha256_pkg;

  localparam int BLOCK_BITS = 512;
  localparam int MAX_BUF    = 4;

  typedef struct packed {
    logic first;
    logic last;
  } blk_flags_t;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_FILL = 1'b1
  } ld_state_e;

  function automatic int wpb(input int data_w);
    return BLOCK_BITS / data_w;
  endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// rtl/sha256_blk_buf.sv - one 512-bit message block buffer with flags and full bit
//
// Purpose:
//   Holds one message block. Words are written by slot index, slot 0 landing in
//   the most significant DATA_W bits. The first/last flags are captured with the
//   slot-0 write. The full bit is set by the loader when the last slot is written
//   and cleared when the block is handed to the core.
// Ports:
//   clk_i       in   clock, rising edge
//   rst_ni      in   synchronous active-low reset
//   wr_en_i     in   write wr_data_i into slot wr_idx_i
//   wr_idx_i    in   slot index 0..WPB-1
//   wr_data_i   in   word to store
//   flags_i     in   first/last flags, captured when slot 0 is written
//   set_full_i  in   mark buffer full
//   clr_full_i  in   mark buffer empty
//   data_o      out  stored 512-bit block
//   flags_o     out  stored flags
//   full_o      out  full bit

module sha256_blk_buf
  import sha256_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WPB    = 16,
  parameter int IDX_W  = $clog2(WPB)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  blk_flags_t            flags_i,
  input  logic                  set_full_i,
  input  logic                  clr_full_i,
  output logic [BLOCK_BITS-1:0] data_o,
  output blk_flags_t            flags_o,
  output logic                  full_o
);

  logic [BLOCK_BITS-1:0] data_q;
  blk_flags_t            flags_q;
  logic                  full_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= '0;
      flags_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (wr_en_i) begin
        data_q[BLOCK_BITS-1-int'(wr_idx_i)*DATA_W -: DATA_W] <= wr_data_i;
        if (wr_idx_i == '0) begin
          flags_q <= flags_i;
        end
      end
      // The loader never completes and drains the same buffer in one cycle,
      // so the ordering of set and clear only matters for robustness.
      if (set_full_i) begin
        full_q <= 1'b1;
      end else if (clr_full_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign flags_o = flags_q;
  assign full_o  = full_q;

endmodule

// File: rtl/sha256_block_loader.sv
// rtl/sha256_block_loader.sv - host word collector presenting 512-bit blocks to the SHA-256 core
//
// Purpose:
//   Packs DATA_W-bit host words into 512-bit blocks across NUM_BUF rotating
//   buffers and offers each complete block, with its first/last flags, over a
//   valid/ready handshake. Supports flush of the partial block and a sticky
//   overflow flag for words offered while every buffer is full.
// Configuration:
//   SHA_LOADER_BSWAP_EN : when defined, each accepted word is byte-reversed
//                         before storage (little-endian hosts).
// Parameters:
//   DATA_W  host word width, 32 or 64
//   NUM_BUF number of block buffers, 1..4
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-low reset
//   data         in   host word (word 0 of a block is most significant)
//   write_enable in   host word valid
//   first_block  in   first-of-message flag, sampled on word 0
//   last_block   in   last-of-message flag, sampled on word 0
//   flush        in   discard the partially filled block
//   in_ready     out  a word can be accepted this cycle
//   blk_valid    out  complete block available
//   blk_ready    in   core takes the block
//   blk_data     out  block, word 0 at [511:512-DATA_W]
//   blk_first    out  first flag of presented block
//   blk_last     out  last flag of presented block
//   busy         out  any full buffer or a partial block in progress
//   overflow     out  sticky: word offered while in_ready low

module sha256_block_loader
  import sha256_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_BUF = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data,
  input  logic                  write_enable,
  input  logic                  first_block,
  input  logic                  last_block,
  input  logic                  flush,
  output logic                  in_ready,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [BLOCK_BITS-1:0] blk_data,
  output logic                  blk_first,
  output logic                  blk_last,
  output logic                  busy,
  output logic                  overflow
);

  localparam int WPB       = wpb(DATA_W);
  localparam int CNT_W     = $clog2(WPB);
  localparam int PTR_W     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int FCNT_W    = $clog2(NUM_BUF + 1);
  // Buffer arrays are padded to a power of two so that any pointer value indexes
  // a real entry; padding slots read as zero and are never selected.
  localparam int BUF_SLOTS = 1 << PTR_W;

  ld_state_e          state_q;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]  full_cnt_q, full_cnt_d;
  logic               overflow_q, overflow_d;

  logic               accept;
  logic               complete;
  logic               xfer;
  logic [DATA_W-1:0]  wr_word;
  blk_flags_t         wr_flags;

  logic [BLOCK_BITS-1:0] buf_data  [BUF_SLOTS];
  blk_flags_t            buf_flags [BUF_SLOTS];
  logic [NUM_BUF-1:0]    buf_full;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_BUF - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake and status derive only from registered state.
  assign in_ready  = (full_cnt_q != FCNT_W'(NUM_BUF));
  assign blk_valid = (full_cnt_q != '0);

  // A word presented alongside flush is dropped without counting as overflow.
  assign accept   = write_enable & in_ready & ~flush;
  assign complete = accept & (word_cnt_q == CNT_W'(WPB - 1));
  assign xfer     = blk_valid & blk_ready;

  assign wr_flags = '{first: first_block, last: last_block};

`ifdef SHA_LOADER_BSWAP_EN
  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_bswap
    assign wr_word[b*8 +: 8] = data[DATA_W-1-b*8 -: 8];
  end
`else
  assign wr_word = data;
`endif

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (flush) begin
      word_cnt_d = '0;
    end else if (accept) begin
      word_cnt_d = complete ? '0 : word_cnt_q + 1'b1;
    end

    wr_ptr_d = complete ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = xfer ? ptr_next(rd_ptr_q) : rd_ptr_q;

    // Completion and transfer in the same cycle leave the count unchanged.
    full_cnt_d = full_cnt_q;
    unique case ({complete, xfer})
      2'b10:   full_cnt_d = full_cnt_q + 1'b1;
      2'b01:   full_cnt_d = full_cnt_q - 1'b1;
      default: full_cnt_d = full_cnt_q;
    endcase

    overflow_d = overflow_q | (write_enable & ~in_ready & ~flush);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= LD_IDLE;
      word_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_cnt_q <= full_cnt_d;
      overflow_q <= overflow_d;
      unique case (state_q)
        LD_IDLE: if (accept && !flush) state_q <= LD_FILL;
        LD_FILL: if (flush || complete) state_q <= LD_IDLE;
        default: state_q <= LD_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < BUF_SLOTS; i++) begin : g_buf
    if (i < NUM_BUF) begin : g_real
      sha256_blk_buf #(
        .DATA_W (DATA_W),
        .WPB    (WPB)
      ) u_buf (
        .clk_i      (clk),
        .rst_ni     (reset),
        .wr_en_i    (accept && (wr_ptr_q == PTR_W'(i))),
        .wr_idx_i   (word_cnt_q),
        .wr_data_i  (wr_word),
        .flags_i    (wr_flags),
        .set_full_i (complete && (wr_ptr_q == PTR_W'(i))),
        .clr_full_i (xfer && (rd_ptr_q == PTR_W'(i))),
        .data_o     (buf_data[i]),
        .flags_o    (buf_flags[i]),
        .full_o     (buf_full[i])
      );
    end else begin : g_pad
      assign buf_data[i]  = '0;
      assign buf_flags[i] = '0;
    end
  end

  assign blk_data  = buf_data[rd_ptr_q];
  assign blk_first = buf_flags[rd_ptr_q].first;
  assign blk_last  = buf_flags[rd_ptr_q].last;
  assign busy      = (|buf_full) | (state_q == LD_FILL);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sha256_block_loader.sv
// tb/tb_sha256_block_loader.sv - scoreboard testbench for sha256_block_loader
`timescale 1ns/1ps

module tb_sha256_block_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, two-buffer instance
  logic         rst_n, we, fb, lb, flush, blk_ready;
  logic [31:0]  data;
  logic         in_ready, blk_valid, blk_first, blk_last, busy, overflow;
  logic [511:0] blk_data;

  // 64-bit, single-buffer instance
  logic         rst64_n, we64, fb64, lb64, flush64, blk_ready64;
  logic [63:0]  data64;
  logic         in_ready64, blk_valid64, blk_first64, blk_last64, busy64, overflow64;
  logic [511:0] blk_data64;

  sha256_block_loader #(.DATA_W(32), .NUM_BUF(2)) u_dut (
    .clk(clk), .reset(rst_n), .data(data), .write_enable(we),
    .first_block(fb), .last_block(lb), .flush(flush), .in_ready(in_ready),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .busy(busy), .overflow(overflow)
  );

  sha256_block_loader #(.DATA_W(64), .NUM_BUF(1)) u_dut64 (
    .clk(clk), .reset(rst64_n), .data(data64), .write_enable(we64),
    .first_block(fb64), .last_block(lb64), .flush(flush64), .in_ready(in_ready64),
    .blk_valid(blk_valid64), .blk_ready(blk_ready64), .blk_data(blk_data64),
    .blk_first(blk_first64), .blk_last(blk_last64), .busy(busy64), .overflow(overflow64)
  );

  typedef struct packed {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  blk_t         exp_q[$];
  int           tests = 0;
  int           fails = 0;
  logic [511:0] m_data;
  logic         m_first, m_last;
  int           m_cnt = 0;
  logic         watch64 = 1'b0;
  logic         valid_seen64 = 1'b0;

  function automatic logic [31:0] swap32(input logic [31:0] w);
`ifdef SHA_LOADER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [63:0] swap64(input logic [63:0] w);
`ifdef SHA_LOADER_BSWAP_EN
    return {swap32(w[31:0]), swap32(w[63:32])};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer is compared against the oldest expected block.
  always @(negedge clk) begin
    blk_t e;
    if (rst_n && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_block", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("blk_data", blk_data, e.data);
        check("blk_first", blk_first, e.first);
        check("blk_last", blk_last, e.last);
      end
    end
    if (watch64 && blk_valid64) valid_seen64 = 1'b1;
  end

  task automatic model_word(input logic [31:0] w, input logic f, input logic l);
    if (m_cnt == 0) begin
      m_first = f;
      m_last  = l;
    end
    m_data[511 - m_cnt*32 -: 32] = swap32(w);
    m_cnt++;
    if (m_cnt == 16) begin
      exp_q.push_back('{data: m_data, first: m_first, last: m_last});
      m_cnt = 0;
    end
  endtask

  task automatic send(input logic [31:0] w, input logic f, input logic l);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      data = w; fb = f; lb = l; we = 1'b1;
      model_word(w, f, l);
      @(posedge clk); #1;
      we = 1'b0;
    end
  endtask

  task automatic drop(input logic [31:0] w);
    data = w; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic send64(input logic [63:0] w, input logic f, input logic l);
    data64 = w; fb64 = f; lb64 = l; we64 = 1'b1;
    @(posedge clk); #1;
    we64 = 1'b0;
  endtask

  initial begin
    logic [511:0] exp64;
    logic [511:0] got;
    rst_n = 1'b0; we = 1'b0; fb = 1'b0; lb = 1'b0; flush = 1'b0; blk_ready = 1'b0; data = '0;
    rst64_n = 1'b0; we64 = 1'b0; fb64 = 1'b0; lb64 = 1'b0; flush64 = 1'b0; blk_ready64 = 1'b0; data64 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; rst64_n = 1'b1;

    // Reset state
    check("rst_blk_valid", blk_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_blk_first", blk_first, 0);
    check("rst_blk_last", blk_last, 0);
    check("rst_blk_data", blk_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst64_in_ready", in_ready64, 1);

    // Test 1: one block 0..15, first=last=1, one-cycle latency to blk_valid
    blk_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(32'(i), 1'b1, 1'b1);
    check("t1_valid_early", blk_valid, 0);
    check("t1_busy_partial", busy, 1);
    send(32'h0000000F, 1'b1, 1'b1);
    check("t1_valid_latency", blk_valid, 1);
    check("t1_word0", blk_data[511:480], swap32(32'h00000000));
    check("t1_word15", blk_data[31:0], swap32(32'h0000000F));
    check("t1_first_last", {blk_first, blk_last}, 2'b11);
    drain();
    check("t1_valid_after_xfer", blk_valid, 0);

    // Test 4: flush after 7 words; a word alongside flush is dropped quietly
    for (int i = 0; i < 7; i++) send(32'h100 + 32'(i), (i == 0), 1'b0);
    data = 32'hDEADBEEF; we = 1'b1; flush = 1'b1;
    m_cnt = 0;
    @(posedge clk); #1;
    we = 1'b0; flush = 1'b0;
    check("t4_no_overflow", overflow, 0);
    check("t4_busy_cleared", busy, 0);
    for (int i = 0; i < 16; i++) send(32'hA5A5A5A5, (i != 0), (i == 0));
    drain();

    // Test 3: block B completes in the same cycle block A transfers
    blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(32'h3000 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) send(32'h3100 + 32'(i), 1'b0, 1'b1);
    check("t3_valid_before", blk_valid, 1);
    blk_ready = 1'b1;
    send(32'h310F, 1'b0, 1'b1);
    check("t3_no_bubble", blk_valid, 1);
    check("t3_one_full", in_ready, 1);
    drain();

    // Test 2: backpressure, dropped word, sticky overflow
    blk_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(32'h2000 + 32'(i), (i == 0), 1'b0);
    check("t2_in_ready_low", in_ready, 0);
    check("t2_overflow_clear", overflow, 0);
    drop(32'h2020);
    check("t2_overflow_set", overflow, 1);
    blk_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(32'h2021 + 32'(i), 1'b0, 1'b1);
    drain();
    check("t2_overflow_sticky", overflow, 1);

    // Test 6: byte order of word 0
    blk_ready = 1'b0;
    send(32'h01020304, 1'b1, 1'b1);
    for (int i = 1; i < 16; i++) send(32'h0, 1'b1, 1'b1);
`ifdef SHA_LOADER_BSWAP_EN
    check("t6_byte_order", blk_data[511:480], 32'h04030201);
`else
    check("t6_byte_order", blk_data[511:480], 32'h01020304);
`endif
    blk_ready = 1'b1;
    drain();

    // Reset clears overflow
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    check("t2_overflow_reset", overflow, 0);
    check("t2_in_ready_reset", in_ready, 1);

    // Test 5: 64-bit, one buffer; reset at word 5 loses the partial block
    blk_ready64 = 1'b1;
    for (int i = 0; i < 5; i++) send64(64'(i), 1'b1, 1'b1);
    check("t5_busy_mid", busy64, 1);
    data64 = 64'h5; we64 = 1'b1; rst64_n = 1'b0;
    watch64 = 1'b1;
    @(posedge clk); #1;
    we64 = 1'b0; rst64_n = 1'b1;
    check("t5_valid_after_rst", blk_valid64, 0);
    check("t5_busy_after_rst", busy64, 0);
    check("t5_in_ready_after_rst", in_ready64, 1);
    repeat (4) @(posedge clk);
    #1;
    watch64 = 1'b0;
    check("t5_valid_never", valid_seen64, 0);

    // 64-bit block packing
    blk_ready64 = 1'b0;
    exp64 = '0;
    for (int i = 0; i < 8; i++) begin
      exp64[511 - i*64 -: 64] = swap64(64'h1111_2222_0000_0000 + 64'(i));
      send64(64'h1111_2222_0000_0000 + 64'(i), (i == 0), 1'b0);
    end
    got = blk_data64;
    check("t5_valid64", blk_valid64, 1);
    check("t5_in_ready64_full", in_ready64, 0);
    check("t5_data64", got, exp64);
    check("t5_flags64", {blk_first64, blk_last64}, 2'b10);
    blk_ready64 = 1'b1;
    @(posedge clk); #1;
    check("t5_valid64_xfer", blk_valid64, 0);
    check("t5_busy64_idle", busy64, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
